speaker_load: RTL

Left-justified serial transmitter for the audio CODEC DAC path; the playback counterpart of the microphone capture block. It accepts N-bit mono samples over a valid/ready handshake into a one-entry holding register. It then shifts each sample MSB-first onto DACDAT, framed by the CODEC-driven DACLRC. Each sample is sent on the left channel (DACLRC high) and repeated on the right channel (DACLRC low).

---
 rtl/speaker_load_if.sv | 12 +
 rtl/speaker_load.sv | 93 +++++++++
 2 files changed

// File: rtl/speaker_load_if.sv
// Upstream sample handshake into the DAC serializer: valid/ready with one
// N-bit two's-complement mono sample per transfer.
interface speaker_load_if #(
  parameter int N = 16
);
  logic         valid;
  logic [N-1:0] sample_data;
  logic         ready;

  modport master (output valid, output sample_data, input ready);
  modport slave  (input valid, input sample_data, output ready);
endinterface

// File: rtl/speaker_load.sv
// Left-justified, MSB-first DAC serializer framed by the CODEC's DACLRC; each
// held sample is sent on the left channel and repeated on the right channel.
module speaker_load #(
  parameter int N = 16
) (
  input  logic            bclk,
  input  logic            reset_n,
  input  logic            daclrc,
  speaker_load_if.slave   s_if,
  output logic            dacdat,
  output logic            underrun
);

  localparam int BW = $clog2(N + 1);
  localparam int IW = $clog2(N);

  logic          r_daclrc_q;
  logic          r_primed;
  logic [N-1:0]  r_hold;
  logic          r_hold_full;
  logic [N-1:0]  r_tx;
  logic [BW-1:0] r_bit_index;
  logic          r_active;

  logic          w_redge;
  logic          w_fedge;
  logic          w_accept;
  logic [IW-1:0] w_idx;

  // Edges are masked until one clock after reset so a DACLRC that is already
  // high at release cannot masquerade as a frame start.
  assign w_redge  = r_primed &  daclrc & ~r_daclrc_q;
  assign w_fedge  = r_primed & ~daclrc &  r_daclrc_q;

  assign s_if.ready = ~r_hold_full & reset_n;
  assign w_accept   = s_if.valid & s_if.ready;
  assign underrun   = w_redge & ~r_hold_full;

  assign w_idx = IW'(N - 1) - r_bit_index[IW-1:0];

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    dacdat = 1'b0;
    if (w_redge)       dacdat = r_hold_full ? r_hold[N-1] : 1'b0;
    else if (w_fedge)  dacdat = r_tx[N-1];
    else if (r_active) dacdat = r_tx[w_idx];
  end

  // NOTE: state registers use non-blocking assignments so every register in
  // this block samples the pre-edge values, independent of statement order.
  always_ff @(posedge bclk or negedge reset_n) begin
    if (!reset_n) begin
      r_daclrc_q  <= 1'b0;
      r_primed    <= 1'b0;
      // NOTE: the sample storage is cleared as well, because a held sample
      // must be discarded on reset and never transmitted afterwards.
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_tx        <= '0;
      r_bit_index <= '0;
      r_active    <= 1'b0;
    end else begin
      r_daclrc_q <= daclrc;
      r_primed   <= 1'b1;

      // ready is low while full, so an accept never coincides with a consume.
      if (w_redge && r_hold_full) begin
        r_hold_full <= 1'b0;
      end else if (w_accept) begin
        r_hold      <= s_if.sample_data;
        r_hold_full <= 1'b1;
      end

      if (w_redge) begin
        r_tx        <= r_hold_full ? r_hold : '0;
        r_bit_index <= BW'(1);
        r_active    <= 1'b1;
      end else if (w_fedge) begin
        r_bit_index <= BW'(1);
        r_active    <= 1'b1;
      end else if (r_active) begin
        if (r_bit_index == BW'(N - 1)) begin
          r_active    <= 1'b0;
          r_bit_index <= BW'(N);
        end else begin
          r_bit_index <= r_bit_index + BW'(1);
        end
      end
    end
  end

endmodule
